// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: decode/execute/memory/writeback hazard inputs and
// the stall/flush/forward controls plus performance counters.
interface hazard_ctrl_if #(
    parameter int unsigned ADW  = 5,
    parameter int unsigned CNTW = 16
);
    logic            validD;
    logic [ADW-1:0]  rs1D;
    logic [ADW-1:0]  rs2D;
    logic            use_rs1D;
    logic            use_rs2D;
    logic [ADW-1:0]  rdE;
    logic            regwriteE;
    logic            resultsrcE;
    logic [ADW-1:0]  rdM;
    logic            regwriteM;
    logic [ADW-1:0]  rdW;
    logic            regwriteW;
    logic            redirectE;
    logic            stallF;
    logic            stallD;
    logic            flushD;
    logic            flushE;
    logic [1:0]      fwdAE;
    logic [1:0]      fwdBE;
    logic            busy;
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] flush_cnt;

    modport master (
        output validD, rs1D, rs2D, use_rs1D, use_rs2D, rdE, regwriteE, resultsrcE,
               rdM, regwriteM, rdW, regwriteW, redirectE,
        input  stallF, stallD, flushD, flushE, fwdAE, fwdBE, busy, stall_cnt, flush_cnt
    );

    modport slave (
        input  validD, rs1D, rs2D, use_rs1D, use_rs2D, rdE, regwriteE, resultsrcE,
               rdM, regwriteM, rdW, regwriteW, redirectE,
        output stallF, stallD, flushD, flushE, fwdAE, fwdBE, busy, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rv32i pipeline hazard controller: load-use bubbles, redirect flush sequence,
// execute-stage operand forwarding selects and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int unsigned ADW       = 5,
    parameter int unsigned FLUSH_CYC = 2,
    parameter int unsigned CNTW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {Run, Stall, Flush} stateT;

    localparam logic [2:0] FcntLoad = 3'(FLUSH_CYC - 1);

    stateT           stateQ, stateD;
    logic [2:0]      fcntQ, fcntD;
    logic [ADW-1:0]  rs1EQ, rs2EQ;
    logic [CNTW-1:0] stallCntQ, flushCntQ;
    logic            lu;
    logic            stallFc, stallDc, flushDc, flushEc;

    assign lu = hz.validD & hz.resultsrcE & hz.regwriteE & (hz.rdE != '0) &
                ((hz.use_rs1D & (hz.rs1D == hz.rdE)) | (hz.use_rs2D & (hz.rs2D == hz.rdE)));

    always_comb begin
        stateD  = stateQ;
        fcntD   = fcntQ;
        stallFc = 1'b0;
        stallDc = 1'b0;
        flushDc = 1'b0;
        flushEc = 1'b0;
        unique case (stateQ)
            Run, Stall: begin
                if (hz.redirectE) begin
                    stateD  = Flush;
                    fcntD   = FcntLoad;
                    flushDc = 1'b1;
                    flushEc = 1'b1;
                end else if (lu && stateQ == Run) begin
                    stateD  = Stall;
                    stallFc = 1'b1;
                    stallDc = 1'b1;
                    flushEc = 1'b1;
                end else begin
                    stateD = Run;
                end
            end
            Flush: begin
                flushDc = 1'b1;
                flushEc = 1'b1;
                // The redirect cycle itself is the first flush cycle, so leave
                // once the remaining count is exhausted.
                if (hz.redirectE) begin
                    fcntD = FcntLoad;
                end else if (fcntQ <= 3'd1) begin
                    stateD = Run;
                    fcntD  = 3'd0;
                end else begin
                    fcntD = fcntQ - 3'd1;
                end
            end
            default: stateD = Run;
        endcase
        // Reset forces quiet outputs even while redirect/lu inputs are active.
        if (rst) begin
            stallFc = 1'b0;
            stallDc = 1'b0;
            flushDc = 1'b0;
            flushEc = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= Run;
            fcntQ     <= 3'd0;
            rs1EQ     <= '0;
            rs2EQ     <= '0;
            stallCntQ <= '0;
            flushCntQ <= '0;
        end else begin
            stateQ <= stateD;
            fcntQ  <= fcntD;
            // Invalid decode slots load x0 so unknown addresses never reach forwarding.
            if (flushEc) begin
                rs1EQ <= '0;
                rs2EQ <= '0;
            end else if (!stallDc) begin
                rs1EQ <= hz.validD ? hz.rs1D : '0;
                rs2EQ <= hz.validD ? hz.rs2D : '0;
            end
            if (stallDc && stallCntQ != '1) stallCntQ <= stallCntQ + 1'b1;
            if (flushDc && flushCntQ != '1) flushCntQ <= flushCntQ + 1'b1;
        end
    end

    function automatic logic [1:0] fwdSel(input logic [ADW-1:0] rs,
                                          input logic regwriteM, input logic [ADW-1:0] rdM,
                                          input logic regwriteW, input logic [ADW-1:0] rdW);
        if (regwriteM && rdM != '0 && rdM == rs)      return 2'b10;
        else if (regwriteW && rdW != '0 && rdW == rs) return 2'b01;
        else                                          return 2'b00;
    endfunction

    assign hz.fwdAE     = fwdSel(rs1EQ, hz.regwriteM, hz.rdM, hz.regwriteW, hz.rdW);
    assign hz.fwdBE     = fwdSel(rs2EQ, hz.regwriteM, hz.rdM, hz.regwriteW, hz.rdW);
    assign hz.stallF    = stallFc;
    assign hz.stallD    = stallDc;
    assign hz.flushD    = flushDc;
    assign hz.flushE    = flushEc;
    assign hz.busy      = (stateQ != Run);
    assign hz.stall_cnt = stallCntQ;
    assign hz.flush_cnt = flushCntQ;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (FLUSH_CYC=2).
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nAssert = 0;
    int   nFail   = 0;

    hazard_ctrl_if #(.ADW(5), .CNTW(16)) hz ();

    hazard_ctrl #(.ADW(5), .FLUSH_CYC(2), .CNTW(16)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        hz.validD     = 1'b0;
        hz.rs1D       = '0;
        hz.rs2D       = '0;
        hz.use_rs1D   = 1'b0;
        hz.use_rs2D   = 1'b0;
        hz.rdE        = '0;
        hz.regwriteE  = 1'b0;
        hz.resultsrcE = 1'b0;
        hz.rdM        = '0;
        hz.regwriteM  = 1'b0;
        hz.rdW        = '0;
        hz.regwriteW  = 1'b0;
        hz.redirectE  = 1'b0;
    endtask

    task automatic setLoadUse();
        hz.validD     = 1'b1;
        hz.rs1D       = 5'd5;
        hz.use_rs1D   = 1'b1;
        hz.rdE        = 5'd5;
        hz.regwriteE  = 1'b1;
        hz.resultsrcE = 1'b1;
    endtask

    initial begin
        idle();
        #1;
        chk("rst_stallF", 32'(hz.stallF), 0);
        chk("rst_flushD", 32'(hz.flushD), 0);
        chk("rst_flushE", 32'(hz.flushE), 0);
        chk("rst_busy", 32'(hz.busy), 0);
        chk("rst_fwdAE", 32'(hz.fwdAE), 0);
        chk("rst_stall_cnt", 32'(hz.stall_cnt), 0);
        chk("rst_flush_cnt", 32'(hz.flush_cnt), 0);
        @(negedge clk); rst = 1'b0;

        // Load-use on x5: one bubble cycle, then a one-cycle STALL state.
        @(negedge clk); setLoadUse(); #1;
        chk("lu_stallF", 32'(hz.stallF), 1);
        chk("lu_stallD", 32'(hz.stallD), 1);
        chk("lu_flushE", 32'(hz.flushE), 1);
        chk("lu_flushD", 32'(hz.flushD), 0);
        @(negedge clk); #1;
        chk("stall_st_stallF", 32'(hz.stallF), 0);
        chk("stall_st_flushE", 32'(hz.flushE), 0);
        chk("stall_st_busy", 32'(hz.busy), 1);
        @(negedge clk); hz.resultsrcE = 1'b0; #1;
        chk("lu_done_busy", 32'(hz.busy), 0);
        chk("lu_stall_cnt", 32'(hz.stall_cnt), 1);

        // Load into x0 never stalls.
        @(negedge clk); hz.rdE = '0; hz.rs1D = '0; hz.resultsrcE = 1'b1; #1;
        chk("x0_stallF", 32'(hz.stallF), 0);
        chk("x0_flushE", 32'(hz.flushE), 0);

        // Forwarding priority with rs1E=3, rs2E=0.
        @(negedge clk); idle(); hz.validD = 1'b1; hz.rs1D = 5'd3;
        @(negedge clk); hz.rdM = 5'd3; hz.regwriteM = 1'b1; hz.rdW = 5'd3; hz.regwriteW = 1'b1; #1;
        chk("fwd_M_prio", 32'(hz.fwdAE), 32'h2);
        chk("fwd_B_x0", 32'(hz.fwdBE), 0);
        @(negedge clk); hz.regwriteM = 1'b0; #1;
        chk("fwd_W", 32'(hz.fwdAE), 32'h1);
        @(negedge clk); hz.regwriteM = 1'b1; hz.rdM = '0; #1;
        chk("fwd_M_rd0", 32'(hz.fwdAE), 32'h1);
        @(negedge clk); hz.regwriteW = 1'b0; #1;
        chk("fwd_none", 32'(hz.fwdAE), 0);

        // Single redirect: two flush cycles.
        @(negedge clk); idle(); hz.redirectE = 1'b1; #1;
        chk("rd1_flushD", 32'(hz.flushD), 1);
        chk("rd1_flushE", 32'(hz.flushE), 1);
        chk("rd1_stallF", 32'(hz.stallF), 0);
        @(negedge clk); hz.redirectE = 1'b0; #1;
        chk("rd2_flushD", 32'(hz.flushD), 1);
        chk("rd2_busy", 32'(hz.busy), 1);
        @(negedge clk); #1;
        chk("rd3_flushD", 32'(hz.flushD), 0);
        chk("rd3_busy", 32'(hz.busy), 0);
        chk("rd_flush_cnt", 32'(hz.flush_cnt), 2);

        // Second redirect in cycle 2 extends flush to three cycles.
        @(negedge clk); hz.redirectE = 1'b1; #1;
        chk("ext1_flushD", 32'(hz.flushD), 1);
        @(negedge clk); #1;
        chk("ext2_flushD", 32'(hz.flushD), 1);
        @(negedge clk); hz.redirectE = 1'b0; #1;
        chk("ext3_flushD", 32'(hz.flushD), 1);
        chk("ext3_busy", 32'(hz.busy), 1);
        @(negedge clk); #1;
        chk("ext4_flushD", 32'(hz.flushD), 0);
        chk("ext_flush_cnt", 32'(hz.flush_cnt), 5);

        // Redirect coincident with load-use: flush wins, no stall.
        @(negedge clk); setLoadUse(); hz.redirectE = 1'b1; #1;
        chk("co_stallF", 32'(hz.stallF), 0);
        chk("co_flushD", 32'(hz.flushD), 1);
        chk("co_flushE", 32'(hz.flushE), 1);
        @(negedge clk); hz.redirectE = 1'b0; #1;
        chk("co_fl_stallF", 32'(hz.stallF), 0);
        chk("co_fl_flushD", 32'(hz.flushD), 1);
        @(negedge clk); idle(); #1;
        chk("co_busy", 32'(hz.busy), 0);
        chk("co_stall_cnt", 32'(hz.stall_cnt), 1);
        chk("co_flush_cnt", 32'(hz.flush_cnt), 7);

        // Invalid decode slot with unknown fields must stay clean.
        @(negedge clk);
        hz.validD = 1'b0; hz.rs1D = 'x; hz.rs2D = 'x; hz.use_rs1D = 1'bx; hz.use_rs2D = 1'bx;
        hz.rdE = 5'd5; hz.regwriteE = 1'b1; hz.resultsrcE = 1'b1;
        hz.rdM = 5'd5; hz.regwriteM = 1'b1; #1;
        chk("xv_stallF", 32'(hz.stallF), 0);
        chk("xv_flushE", 32'(hz.flushE), 0);
        @(negedge clk); #1;
        chk("xv_fwdAE", 32'(hz.fwdAE), 0);
        chk("xv_fwdBE", 32'(hz.fwdBE), 0);

        // Reset in the middle of a flush sequence.
        @(negedge clk); idle(); hz.redirectE = 1'b1;
        @(negedge clk); hz.redirectE = 1'b0; #1;
        chk("mr_busy_pre", 32'(hz.busy), 1);
        rst = 1'b1; hz.redirectE = 1'b1; #1;
        chk("mr_flushD", 32'(hz.flushD), 0);
        chk("mr_flushE", 32'(hz.flushE), 0);
        chk("mr_stallF", 32'(hz.stallF), 0);
        chk("mr_busy", 32'(hz.busy), 0);
        @(negedge clk); rst = 1'b0; hz.redirectE = 1'b0; #1;
        chk("mr_stall_cnt", 32'(hz.stall_cnt), 0);
        chk("mr_flush_cnt", 32'(hz.flush_cnt), 0);
        chk("mr_busy_post", 32'(hz.busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
